router_reg_p: RTL
=================

Name: router_reg_p

Overview:
Parametrised successor of the router's register block. It sits between the router FSM and the per-port FIFOs.
- Latches the header byte and streams payload to dout.
- Holds one byte while the FIFO is full and replays it in the laf state.
- Accumulates a packet check (XOR parity or modular-sum checksum) and flags check and length errors at end of packet.
- Data width, header field widths and check mode are generalised.

Parameters:
DATA_W, 8, byte/word width of data_in and dout.
ADDR_W, 2, header destination field, bits [ADDR_W-1:0]; all-ones address is invalid.
LEN_W, 6, header payload-length field, bits [ADDR_W+LEN_W-1:ADDR_W]; ADDR_W+LEN_W <= DATA_W (elaboration error otherwise).
CHK_MODE, 0, 0 = XOR parity over header+payload; 1 = sum mod 2^DATA_W over header+payload.
LEN_CHECK, 1, 1 = compare received payload count with header length; 0 = len_err tied 0.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
data_in  in  DATA_W  header/payload/check word from source
pkt_valid  in  1  high during header+payload, low on check word
fifo_full  in  1  destination FIFO full
rst_int_reg  in  1  FSM clears low_pkt_valid
detect_add  in  1  FSM in DECODE_ADDRESS
lfd_state  in  1  FSM loading first (header) word
ld_state  in  1  FSM loading data
laf_state  in  1  FSM loading after full
full_state  in  1  FSM in FIFO_FULL_STATE
dout  out  DATA_W  registered word to FIFO
hdr_addr  out  ADDR_W  destination of current packet
parity_done  out  1  check word captured and compared
low_pkt_valid  out  1  pkt_valid fell while loading
err  out  1  check mismatch
len_err  out  1  payload count != header length

Behaviour:
- All outputs and internal registers are registered. Every output is 0 while reset is high; recovery takes effect on the first clock edge after deassertion.
- Header capture: on detect_add & pkt_valid & addr != all-ones, hdr_reg <= data_in and hdr_addr <= addr field. An invalid address leaves hdr_reg unchanged.
- On detect_add, the following are cleared in the same edge: check accumulator, payload counter, parity_done, err, len_err.
- dout priority, one write per edge:
  1. lfd_state: dout <= hdr_reg.
  2. ld_state & !fifo_full: dout <= data_in.
  3. laf_state: dout <= hold_reg.
  4. Otherwise dout holds.
- Hold: ld_state & fifo_full: hold_reg <= data_in; dout unchanged.
- Accumulator (acc), one-cycle latency to the internal register:
  - lfd_state: acc <= acc OP hdr_reg.
  - ld_state & pkt_valid & !full_state: acc <= acc OP data_in, and payload counter +1.
  - OP is XOR (CHK_MODE 0) or DATA_W-bit wrap-around add (CHK_MODE 1).
  - The counter is LEN_W+1 bits and saturates at all-ones.
- Check capture: when ld_state & !pkt_valid & !fifo_full, or laf_state & low_pkt_valid & !parity_done, then pkt_chk <= data_in (or hold_reg in the laf case) and parity_done <= 1.
- One edge after parity_done rises:
  - err <= (acc != pkt_chk).
  - len_err <= LEN_CHECK & (count != length field).
  - err and len_err are sticky until the next detect_add or reset.
- low_pkt_valid: set on ld_state & !pkt_valid; cleared on rst_int_reg. rst_int_reg wins when both occur on the same edge.
- parity_done is set once per packet; a second capture condition before detect_add is ignored.
- Reset mid-packet aborts the packet with no partial err or len_err. The next packet starts only via detect_add.
- Length 0 header: a packet with no payload words is legal; len_err=0 if none are received.

Decomposition:
- Package router_pkg holds:
  - the chk_mode_e enum (CHK_XOR, CHK_SUM);
  - header field localparams and the functions hdr_addr_f / hdr_len_f;
  - the constant ADDR_INVALID.
- One sub-module, router_chk_acc: accumulator + payload counter, parametrised by DATA_W, LEN_W and CHK_MODE.

Test Plan:
1. Reset high mid-stream (ld_state=1, data_in random) -> dout=0, err=0, len_err=0, parity_done=0, low_pkt_valid=0 within the same cycle, without waiting for a clock edge.
2. CHK_MODE=0, header 0x16, payload A1 B2 C3 D4 E5, check 0xF7 -> dout follows each word one cycle later; hdr_addr=2; parity_done=1; err=0, len_err=0.
3. Same packet with C3 sent as C2, check 0xF7 -> err=1 one cycle after parity_done, held until detect_add; then detect_add -> err=0.
4. CHK_MODE=1, same packet with check 0xE5 -> err=0; with check 0xE4 -> err=1.
5. fifo_full=1 while D4 is on data_in, then laf_state -> dout=D4 after laf; acc excludes the duplicate; err=0 with correct check.
6. Header 0x16, only 4 payload words, correct XOR check (0x16^A1^B2^C3^D4 = 0x12) -> err=0, len_err=1. Also ld_state with pkt_valid=0 -> low_pkt_valid=1 next edge; rst_int_reg -> 0.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and header-field helpers for the parametrised router register block.
package router_pkg;

  typedef enum logic {
    CHK_XOR = 1'b0,
    CHK_SUM = 1'b1
  } chk_mode_e;

  // Header helpers work on a zero-extended copy of the word, so any DATA_W up to HDR_MAX_W fits.
  localparam int HDR_MAX_W  = 32;
  localparam int HDR_ADDR_W = 2;
  localparam int HDR_LEN_W  = 6;

  // Truncated to ADDR_W at the use site, so every width sees an all-ones address.
  localparam logic [HDR_MAX_W-1:0] ADDR_INVALID = '1;

  function automatic logic [HDR_MAX_W-1:0] field_mask(input int w);
    return (HDR_MAX_W'(1) << w) - HDR_MAX_W'(1);
  endfunction

  function automatic logic [HDR_MAX_W-1:0] hdr_addr_f(input logic [HDR_MAX_W-1:0] hdr,
                                                      input int addr_w);
    return hdr & field_mask(addr_w);
  endfunction

  function automatic logic [HDR_MAX_W-1:0] hdr_len_f(input logic [HDR_MAX_W-1:0] hdr,
                                                     input int addr_w, input int len_w);
    return (hdr >> addr_w) & field_mask(len_w);
  endfunction

endpackage

// File: rtl/router_chk_acc.sv
// Packet check accumulator (XOR parity or wrap-around sum) plus saturating payload counter.
module router_chk_acc
  import router_pkg::*;
#(
  parameter int        DATA_W   = 8,
  parameter int        LEN_W    = 6,
  parameter chk_mode_e CHK_MODE = CHK_XOR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] add_data,
  input  logic              cnt_en,
  output logic [DATA_W-1:0] acc,
  output logic [LEN_W:0]    count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      count <= '0;
    end else if (clear) begin
      acc   <= '0;
      count <= '0;
    end else begin
      if (add_en) begin
        if (CHK_MODE == CHK_SUM) acc <= acc + add_data;
        else                     acc <= acc ^ add_data;
      end
      // Saturate so an overlong packet cannot wrap back onto a matching length.
      if (cnt_en && (count != '1)) count <= count + (LEN_W+1)'(1);
    end
  end

endmodule

// File: rtl/router_reg_p.sv
// Router register block: header latch, payload/hold datapath to the FIFO, and end-of-packet checks.
// pkt_valid marks header/payload words (low on the check word); fifo_full is backpressure: a word
// presented in ld_state while full is parked in hold_reg and replayed from laf_state.
module router_reg_p
  import router_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = HDR_ADDR_W,
  parameter int LEN_W     = HDR_LEN_W,
  parameter int CHK_MODE  = 0,
  parameter int LEN_CHECK = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              rst_int_reg,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] hdr_addr,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err,
  output logic              len_err
);

  if (ADDR_W + LEN_W > DATA_W) begin : g_bad_hdr
    $error("router_reg_p: ADDR_W + LEN_W exceeds DATA_W");
  end
  if (DATA_W > HDR_MAX_W || CHK_MODE < 0 || CHK_MODE > 1) begin : g_bad_cfg
    $error("router_reg_p: unsupported DATA_W or CHK_MODE");
  end

  logic [DATA_W-1:0] hdr_reg, hold_reg, pkt_chk, acc;
  logic [LEN_W:0]    count;
  logic [ADDR_W-1:0] in_addr;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_ok, chk_ld, chk_laf, done_q, pl_take;

  assign in_addr = ADDR_W'(hdr_addr_f(HDR_MAX_W'(data_in), ADDR_W));
  assign hdr_len = LEN_W'(hdr_len_f(HDR_MAX_W'(hdr_reg), ADDR_W, LEN_W));
  assign hdr_ok  = detect_add && pkt_valid && (in_addr != ADDR_W'(ADDR_INVALID));
  assign chk_ld  = ld_state && !pkt_valid && !fifo_full;
  assign chk_laf = laf_state && low_pkt_valid && !parity_done;
  // full_state gates counting so the word already parked in hold_reg is never seen twice.
  assign pl_take = ld_state && pkt_valid && !full_state;

  router_chk_acc #(
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W),
    .CHK_MODE(chk_mode_e'(CHK_MODE))
  ) u_chk_acc (
    .clock   (clock),
    .reset   (reset),
    .clear   (detect_add),
    .add_en  (lfd_state || pl_take),
    .add_data(lfd_state ? hdr_reg : data_in),
    .cnt_en  (pl_take && !lfd_state),
    .acc     (acc),
    .count   (count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hdr_reg  <= '0;
      hdr_addr <= '0;
      hold_reg <= '0;
      dout     <= '0;
    end else begin
      if (hdr_ok) begin
        hdr_reg  <= data_in;
        hdr_addr <= in_addr;
      end
      if (ld_state && fifo_full) hold_reg <= data_in;
      if (lfd_state)                      dout <= hdr_reg;
      else if (ld_state && !fifo_full)    dout <= data_in;
      else if (laf_state)                 dout <= hold_reg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                   low_pkt_valid <= 1'b0;
    else if (rst_int_reg)        low_pkt_valid <= 1'b0;
    else if (ld_state && !pkt_valid) low_pkt_valid <= 1'b1;
  end

  // done_q delays parity_done by one edge so the compare sees the settled acc and pkt_chk.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_chk     <= '0;
      parity_done <= 1'b0;
      done_q      <= 1'b0;
      err         <= 1'b0;
      len_err     <= 1'b0;
    end else if (detect_add) begin
      parity_done <= 1'b0;
      done_q      <= 1'b0;
      err         <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      done_q <= parity_done;
      if (!parity_done && (chk_ld || chk_laf)) begin
        pkt_chk     <= chk_ld ? data_in : hold_reg;
        parity_done <= 1'b1;
      end
      if (parity_done && !done_q) begin
        err     <= (acc != pkt_chk);
        len_err <= (LEN_CHECK != 0) && (count != {1'b0, hdr_len});
      end
    end
  end

endmodule
